// File: rtl/core_types_pkg.sv
// core_types_pkg: shared core types and sizing for the rename/free-list logic
package core_types_pkg;
   localparam int NUM_ARCH_REGS = 32;
   localparam int NUM_PHYS_REGS = 64;
   localparam int FREE_LIST_DEPTH = 64;
   localparam int LOG_FREE_LIST_DEPTH = $clog2(FREE_LIST_DEPTH);
   localparam int CHECKPOINT_COLUMNS = 4;
   localparam int FREE_LIST_RESET_COUNT = NUM_PHYS_REGS - NUM_ARCH_REGS;
   typedef logic [$clog2(NUM_PHYS_REGS)-1:0] phys_reg_tag_t;
   typedef logic [$clog2(CHECKPOINT_COLUMNS)-1:0] checkpoint_column_t;
   typedef logic [LOG_FREE_LIST_DEPTH:0] free_list_ptr_t;
endpackage

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular FIFO of free physical register tags with head checkpoints
//   dequeue_*            : pop a tag at head (tag is combinational from the head entry)
//   enqueue_*            : push a freed tag at tail; dropped when full (sets sticky overflow_error)
//   save/restore_checkpoint_* : capture head_next into a column / roll head back from it
//   free_count           : tail - head from the registered pointers
module phys_reg_free_list
   import core_types_pkg::*;
(
   input  logic               CLK,
   input  logic               RST,
   input  logic               dequeue_valid,
   output logic               dequeue_ready,
   output phys_reg_tag_t      dequeue_phys_reg_tag,
   input  logic               enqueue_valid,
   input  phys_reg_tag_t      enqueue_phys_reg_tag,
   input  logic               save_checkpoint_valid,
   input  checkpoint_column_t save_checkpoint_column,
   input  logic               restore_checkpoint_valid,
   input  checkpoint_column_t restore_checkpoint_column,
   output logic [6:0]         free_count,
   output logic               overflow_error
);
   phys_reg_tag_t  entry [FREE_LIST_DEPTH];
   free_list_ptr_t column [CHECKPOINT_COLUMNS];
   free_list_ptr_t head, tail, head_next;
   logic empty, full, enq_fire;
   always_comb begin
      empty = head == tail;
      // wrap bits differ with equal indices: tail has lapped head exactly once
      full = (head[LOG_FREE_LIST_DEPTH] != tail[LOG_FREE_LIST_DEPTH]) &&
             (head[LOG_FREE_LIST_DEPTH-1:0] == tail[LOG_FREE_LIST_DEPTH-1:0]);
      dequeue_ready = !empty && !restore_checkpoint_valid;
      dequeue_phys_reg_tag = entry[head[LOG_FREE_LIST_DEPTH-1:0]];
      enq_fire = enqueue_valid && !full;
      head_next = restore_checkpoint_valid ? column[restore_checkpoint_column] :
                  head + free_list_ptr_t'(dequeue_valid && dequeue_ready);
      free_count = tail - head;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < FREE_LIST_DEPTH; i++)
            entry[i] <= (i < FREE_LIST_RESET_COUNT) ? phys_reg_tag_t'(NUM_ARCH_REGS + i) : '0;
         for (int i = 0; i < CHECKPOINT_COLUMNS; i++)
            column[i] <= '0;
         head <= '0;
         tail <= free_list_ptr_t'(FREE_LIST_RESET_COUNT);
         overflow_error <= 1'b0;
      end else begin
         head <= head_next;
         if (enq_fire) begin
            entry[tail[LOG_FREE_LIST_DEPTH-1:0]] <= enqueue_phys_reg_tag;
            tail <= tail + 1'b1;
         end
         if (enqueue_valid && full)
            overflow_error <= 1'b1;
         if (save_checkpoint_valid && !restore_checkpoint_valid)
            column[save_checkpoint_column] <= head_next;
      end
   end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list: directed self-checking bench for phys_reg_free_list
module tb_phys_reg_free_list;
   import core_types_pkg::*;
   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic               dequeue_valid = 1'b0;
   logic               dequeue_ready;
   phys_reg_tag_t      dequeue_phys_reg_tag;
   logic               enqueue_valid = 1'b0;
   phys_reg_tag_t      enqueue_phys_reg_tag = '0;
   logic               save_checkpoint_valid = 1'b0;
   checkpoint_column_t save_checkpoint_column = '0;
   logic               restore_checkpoint_valid = 1'b0;
   checkpoint_column_t restore_checkpoint_column = '0;
   logic [6:0]         free_count;
   logic               overflow_error;
   int n_tests = 0;
   int n_fail = 0;

   phys_reg_free_list dut (
      .CLK(CLK), .RST(RST),
      .dequeue_valid(dequeue_valid), .dequeue_ready(dequeue_ready),
      .dequeue_phys_reg_tag(dequeue_phys_reg_tag),
      .enqueue_valid(enqueue_valid), .enqueue_phys_reg_tag(enqueue_phys_reg_tag),
      .save_checkpoint_valid(save_checkpoint_valid), .save_checkpoint_column(save_checkpoint_column),
      .restore_checkpoint_valid(restore_checkpoint_valid), .restore_checkpoint_column(restore_checkpoint_column),
      .free_count(free_count), .overflow_error(overflow_error)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      dequeue_valid = 1'b0;
      enqueue_valid = 1'b0;
      save_checkpoint_valid = 1'b0;
      restore_checkpoint_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
   endtask

   task automatic deq();
      dequeue_valid = 1'b1;
      tick();
      idle();
   endtask

   initial begin
      do_reset();
      chk("reset_fc", free_count, 32);
      chk("reset_ready", dequeue_ready, 1);
      chk("reset_tag", dequeue_phys_reg_tag, 32);
      chk("reset_ovf", overflow_error, 0);

      for (int i = 0; i < 32; i++) begin
         chk("drain_tag", dequeue_phys_reg_tag, 32 + i);
         chk("drain_fc", free_count, 32 - i);
         chk("drain_ready", dequeue_ready, 1);
         deq();
      end
      chk("empty_ready", dequeue_ready, 0);
      chk("empty_fc", free_count, 0);
      deq();
      chk("extra_deq_ready", dequeue_ready, 0);
      chk("extra_deq_fc", free_count, 0);

      enqueue_valid = 1'b1;
      enqueue_phys_reg_tag = 6'd5;
      #1;
      chk("no_bypass_ready", dequeue_ready, 0);
      tick();
      idle();
      chk("enq5_ready", dequeue_ready, 1);
      chk("enq5_tag", dequeue_phys_reg_tag, 5);
      chk("enq5_fc", free_count, 1);
      deq();
      chk("enq5_deq_fc", free_count, 0);

      do_reset();
      deq();
      deq();
      chk("pre_save_tag", dequeue_phys_reg_tag, 34);
      save_checkpoint_valid = 1'b1;
      save_checkpoint_column = 2'd2;
      deq();
      chk("post_save_tag", dequeue_phys_reg_tag, 35);
      deq();
      deq();
      chk("pre_restore_tag", dequeue_phys_reg_tag, 37);
      restore_checkpoint_valid = 1'b1;
      restore_checkpoint_column = 2'd2;
      tick();
      idle();
      chk("restore2_tag", dequeue_phys_reg_tag, 35);
      chk("restore2_fc", free_count, 29);

      deq();
      save_checkpoint_valid = 1'b1;
      save_checkpoint_column = 2'd1;
      tick();
      idle();
      deq();
      deq();
      chk("pre_r1_tag", dequeue_phys_reg_tag, 38);
      restore_checkpoint_valid = 1'b1;
      restore_checkpoint_column = 2'd1;
      dequeue_valid = 1'b1;
      enqueue_valid = 1'b1;
      enqueue_phys_reg_tag = 6'd7;
      save_checkpoint_valid = 1'b1;
      save_checkpoint_column = 2'd3;
      #1;
      chk("r1_ready_low", dequeue_ready, 0);
      tick();
      idle();
      chk("r1_tag", dequeue_phys_reg_tag, 36);
      chk("r1_fc", free_count, 29);
      restore_checkpoint_valid = 1'b1;
      restore_checkpoint_column = 2'd3;
      tick();
      idle();
      chk("r3_unsaved_tag", dequeue_phys_reg_tag, 32);
      chk("r3_unsaved_fc", free_count, 33);

      do_reset();
      enqueue_valid = 1'b1;
      for (int i = 0; i < 32; i++) begin
         enqueue_phys_reg_tag = phys_reg_tag_t'(i);
         tick();
      end
      idle();
      chk("full_fc", free_count, 64);
      chk("full_ovf", overflow_error, 0);
      enqueue_valid = 1'b1;
      enqueue_phys_reg_tag = 6'd9;
      tick();
      idle();
      chk("overflow_set", overflow_error, 1);
      chk("overflow_fc", free_count, 64);
      tick();
      chk("overflow_sticky", overflow_error, 1);
      chk("full_tag", dequeue_phys_reg_tag, 32);
      RST = 1'b1;
      dequeue_valid = 1'b1;
      enqueue_valid = 1'b1;
      tick();
      RST = 1'b0;
      idle();
      chk("rst_ovf", overflow_error, 0);
      chk("rst_fc", free_count, 32);
      chk("rst_tag", dequeue_phys_reg_tag, 32);

      for (int k = 0; k < 100; k++) begin
         chk("wrap_tag", dequeue_phys_reg_tag, 32 + (k % 32));
         chk("wrap_fc", free_count, 32);
         dequeue_valid = 1'b1;
         enqueue_valid = 1'b1;
         enqueue_phys_reg_tag = dequeue_phys_reg_tag;
         tick();
      end
      idle();
      chk("wrap_end_fc", free_count, 32);
      chk("wrap_end_tag", dequeue_phys_reg_tag, 32 + (100 % 32));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Circular FIFO of unallocated physical register tags for the OoO MIPS core's rename stage. Dispatch pops a fresh destination tag per reg-writing instruction, and the ROB pushes tags back at commit (old safe mapping) or during revert (squashed speculated mapping). Per-column head checkpoints let a branch mispredict restore reclaim every tag popped after the branch in a single cycle. Sits between dispatch/rename and the ROB, alongside the phys reg map table.

## Interface
- FREE_LIST_DEPTH, 64, entries; power of two, ≥ NUM_PHYS_REGS
- NUM_ARCH_REGS, 32, tags 0..NUM_ARCH_REGS-1 are mapped at reset, so they are not free
- NUM_PHYS_REGS, 64, total physical registers
- CHECKPOINT_COLUMNS, 4, saved head slots
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- dequeue_valid  in  1  dispatch requests a tag
- dequeue_ready  out  1  tag available this cycle
- dequeue_phys_reg_tag  out  6  tag at head
- enqueue_valid  in  1  ROB frees a tag
- enqueue_phys_reg_tag  in  6  tag being freed
- save_checkpoint_valid  in  1  capture head
- save_checkpoint_column  in  2  destination column
- restore_checkpoint_valid  in  1  roll head back
- restore_checkpoint_column  in  2  source column
- free_count  out  7  number of free tags, 0..64
- overflow_error  out  1  sticky; set on a dropped enqueue

## Operation
- Pointers are 7 bits: a 6-bit index plus a wrap MSB.
  - empty: head == tail
  - full: MSBs differ and indices are equal
- Reset state:
  - entry[i] = NUM_ARCH_REGS + i for i in 0..31; entries 32..63 = 0
  - head = 0, tail = 32
  - all checkpoint columns = 0
  - free_count = 32, overflow_error = 0
- Dequeue:
  - dequeue_ready = !empty && !restore_checkpoint_valid
  - dequeue_phys_reg_tag = entry[head index]; combinational; driven even when not ready
  - on dequeue_valid && dequeue_ready, head <= head+1
  - dequeue_valid while not ready has no effect
- Enqueue:
  - always accepted unless full
  - on enqueue_valid, entry[tail index] <= tag and tail <= tail+1
  - enqueue while full: dropped, tail unchanged, overflow_error <= 1 until reset
- Save: column[save_checkpoint_column] <= head_next, the head value after this cycle's dequeue, if any.
- Restore:
  - head <= column[restore_checkpoint_column]
  - any same-cycle dequeue is blocked (dequeue_ready is low)
  - same-cycle enqueue still applies to tail
  - same-cycle save is ignored
- free_count = tail − head, modulo 128, computed from the registered pointers.
- Pointers wrap naturally at 128. The wrap MSB distinguishes full from empty.
- Restoring a column never saved since reset restores head = 0. Callers must not do this; it is not checked.

## Timing
- Dequeue tag: 0-cycle latency from the registered head.
- Pointer, entry and free_count updates are visible the cycle after the edge.
- Enqueue into an empty list: dequeue_ready rises the next cycle. There is no enqueue→dequeue bypass.
- Simultaneous dequeue and enqueue: both apply, free_count is unchanged, and head/tail wrap independently.
- Restore: the restored tags are dequeueable the next cycle.
- RST asserted mid-operation overrides all inputs that cycle. Reset state is in force the following cycle.

## Structure
- Add to core_types_pkg:
  - free_list_ptr_t = logic [LOG_FREE_LIST_DEPTH:0]
  - FREE_LIST_RESET_COUNT = NUM_PHYS_REGS − NUM_ARCH_REGS
- Reuse from core_types_pkg: phys_reg_tag_t, checkpoint_column_t, FREE_LIST_DEPTH.
- Single module; no sub-module. The entry array and the checkpoint array are plain register arrays.

## Test plan
- Reset, then 32 consecutive dequeues:
  - tags 32..63 are returned in order
  - dequeue_ready falls after the 32nd dequeue; free_count goes 32→0
  - a 33rd dequeue_valid changes nothing
- Empty list, enqueue tag 5:
  - next cycle: dequeue_ready = 1, tag = 5, free_count = 1
  - dequeue: free_count = 0
- After reset, dequeue twice (tags 32, 33), then save column 2 together with a dequeue of 34. Dequeue 35 and 36, then restore column 2:
  - next cycle: tag = 35, free_count = 29
- Restore column 1 in the same cycle as dequeue_valid and enqueue of tag 7:
  - dequeue_ready = 0 that cycle
  - head = saved value; tail advances by 1
- Enqueue 32 tags after reset (list full, free_count = 64), then enqueue one more:
  - the extra tag is dropped; overflow_error = 1 and stays 1
  - RST clears it and restores free_count = 32
- Head and tail wrap: 100 cycles of simultaneous dequeue+enqueue, tag in = tag out:
  - free_count stays 32
  - the tag sequence repeats 32..63 with no corruption
